// File: rtl/std_shared_alu_arbiter.sv
// Purpose: round-robin share of one left/right/valid -> ready/out arithmetic unit among N requesters.
// Latency: req seen in IDLE -> operands on the unit next cycle -> response pulse the cycle after res_ready (earliest 2 cycles).
// Backpressure: res_valid and operand steering held until res_ready or MAX_WAIT timeout; requesters hold req until their pulse.
//
// Ports:
//   clk, reset (async, active-low)
//   req[N], left_flat/right_flat[N*width]      requester side, slice i belongs to requester i
//   res_valid, res_left, res_right -> unit;    res_ready, res_out <- unit
//   resp_valid[N] (one-hot pulse), resp_data, resp_err (timeout flag) back to the winner
//   busy_cycles: saturating count of non-IDLE cycles when STD_ARB_PERF_EN is defined, else 0
module std_shared_alu_arbiter #(
    parameter int width    = 32,
    parameter int N        = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*width-1:0] left_flat,
    input  logic [N*width-1:0] right_flat,
    output logic               res_valid,
    output logic [width-1:0]   res_left,
    output logic [width-1:0]   res_right,
    input  logic               res_ready,
    input  logic [width-1:0]   res_out,
    output logic [N-1:0]       resp_valid,
    output logic [width-1:0]   resp_data,
    output logic               resp_err,
    output logic [31:0]        busy_cycles
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [N-1:0] GRANT_LSB = N'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick;
    logic [CW-1:0]   wait_cnt;
    logic [N-1:0]    rot;
    logic [PW:0]     pick_sum;
    logic [PW:0]     next_ptr;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        rot      = N'({req, req} >> rr_ptr);
        pick     = rr_ptr;
        pick_sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_sum = {1'b0, rr_ptr} + (PW+1)'(k);
                if (pick_sum >= (PW+1)'(N)) begin
                    pick_sum = pick_sum - (PW+1)'(N);
                end
                pick = pick_sum[PW-1:0];
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        next_ptr = {1'b0, grant} + 1'b1;
        if (next_ptr >= (PW+1)'(N)) begin
            next_ptr = '0;
        end
    end

    // Operands follow the granted slice live while the op is in flight, so a
    // caller that changes them mid-op is seen by the unit unmasked.
    assign res_left  = res_valid ? left_flat[int'(grant)*width +: width]  : '0;
    assign res_right = res_valid ? right_flat[int'(grant)*width +: width] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            res_valid  <= 1'b0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= pick;
                        res_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        resp_valid <= GRANT_LSB << grant;
                        resp_data  <= res_out;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else if (state == WAIT && wait_cnt == CW'(MAX_WAIT)) begin
                        // Unit never answered: report a zero result with the error flag.
                        res_valid  <= 1'b0;
                        resp_valid <= GRANT_LSB << grant;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        // wait_cnt is 0 on entry from ISSUE, so WAIT starts at 1.
                        wait_cnt <= wait_cnt + 1'b1;
                        state    <= WAIT;
                    end
                end
                RESP: begin
                    resp_valid <= '0;
                    resp_data  <= '0;
                    resp_err   <= 1'b0;
                    rr_ptr     <= next_ptr[PW-1:0];
                    wait_cnt   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STD_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cycles <= '0;
        end else if (state != IDLE && busy_cycles != 32'hFFFF_FFFF) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`else
    assign busy_cycles = '0;
`endif

endmodule
